// File: rtl/neuron_mac.sv
// Serial signed MAC neuron: bias + sum of floor(x*w) over N_INPUTS beats.
// Optional accumulator clamping via NEURON_MAC_ACC_SAT_EN (wraps when undefined).
module neuron_mac #(
  parameter int N_INPUTS = 3,
  parameter int G        = 2,
  parameter int QM       = 6,
  parameter int QN       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [QM+QN-1:0]      x,
  input  logic [QM+QN-1:0]      w,
  input  logic [QM+QN+G-1:0]    bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QM+QN+G-1:0]    acc_out
);

  localparam int W  = QM + QN + G;
  localparam int OW = QM + QN;
  localparam int PW = 2 * OW;
  localparam int CW = $clog2(N_INPUTS + 1);

  localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0] P_MAX =
    {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN =
    {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;

  logic signed [PW-1:0] p_full;
  logic signed [PW-1:0] p_shr;
  logic [W-1:0]         p;
  logic [W-1:0]         base;
  logic [W:0]           sum;
  logic [W-1:0]         sum_w;
  logic                 beat;

  // Product is floored by the arithmetic shift, then clamped to W bits.
  always_comb begin
    p_full = $signed(x) * $signed(w);
    p_shr  = p_full >>> QN;
    if (p_shr > P_MAX) begin
      p = MAX_W;
    end else if (p_shr < P_MIN) begin
      p = MIN_W;
    end else begin
      p = p_shr[W-1:0];
    end
  end

  always_comb begin
    base = (state_q == IDLE) ? bias : acc_q;
    sum  = {base[W-1], base} + {p[W-1], p};
`ifdef NEURON_MAC_ACC_SAT_EN
    if (sum[W] != sum[W-1]) begin
      sum_w = sum[W] ? MIN_W : MAX_W;
    end else begin
      sum_w = sum[W-1:0];
    end
`else
    sum_w = sum[W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign beat = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          acc_d   = sum_w;
          cnt_d   = CW'(1);
          state_d = (N_INPUTS == 1) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = sum_w;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N_INPUTS - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q != HOLD);
    out_valid = (state_q == HOLD);
  end

  assign acc_out = acc_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed vectors, expected sums queued
// by the stimulus thread and popped by a monitor on each output handshake.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [15:0] w = '0;
  logic [17:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [17:0] acc_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pop_prev = 0;
  int pop_last = 0;
  int exp_q[$];

  neuron_mac dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .w(w),
    .bias(bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic beat(input logic [15:0] xv, input logic [15:0] wv,
                      input logic [17:0] bv);
    int n;
    logic ok;
    n = 0;
    x = xv;
    w = wv;
    bias = bv;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("beat_timeout", 0, 1);
    #1;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vec3(input logic [17:0] bv, input logic [15:0] xv,
                      input logic [15:0] wv, input int exp);
    exp_q.push_back(exp);
    beat(xv, wv, bv);
    beat(xv, wv, bv);
    beat(xv, wv, bv);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int ov_a;
    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", $signed(acc_out), 0);
          end else begin
            chk("acc_out", $signed(acc_out), exp_q.pop_front());
          end
          pop_prev = pop_last;
          pop_last = cyc;
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // basic sum with latency checks
    vec3(18'd256, 16'h0400, 16'h0200, 1792);
    @(negedge clk);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_in_ready_hold", in_ready, 0);
    @(negedge clk);
    chk("basic_idle_valid", out_valid, 0);
    chk("basic_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // floor rounding
    exp_q.push_back(-1);
    beat(16'hFFFF, 16'h0200, 18'd0);
    beat(16'h0000, 16'h0000, 18'd0);
    beat(16'h0000, 16'h0000, 18'd0);
    in_valid = 1'b0;
    drain();

    // saturation
`ifdef NEURON_MAC_ACC_SAT_EN
    vec3(18'd0, 16'h7FFF, 16'h7FFF, 131071);
`else
    vec3(18'd0, 16'h7FFF, 16'h7FFF, 131069);
`endif
    drain();

    // backpressure and gaps, with a junk beat offered during HOLD
    out_ready = 1'b0;
    exp_q.push_back(1792);
    beat(16'h0400, 16'h0200, 18'd256);
    gap(2);
    beat(16'h0400, 16'h0200, 18'd256);
    beat(16'h0400, 16'h0200, 18'd256);
    x = 16'h7FFF;
    w = 16'h7FFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_acc_stable", $signed(acc_out), 1792);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    vec3(18'd256, 16'h0400, 16'h0200, 1792);
    drain();

    // reset mid-vector, beat offered during reset is dropped
    beat(16'h7FFF, 16'h7FFF, 18'd1000);
    beat(16'h7FFF, 16'h7FFF, 18'd1000);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_acc_out", acc_out, 0);
    @(posedge clk);
    #1;
    vec3(18'd256, 16'h0400, 16'h0200, 1792);
    drain();

    // back-to-back vectors with in_valid held high
    ov_a = checks;
    exp_q.push_back(1792);
    exp_q.push_back(-6400);
    beat(16'h0400, 16'h0200, 18'd256);
    beat(16'h0400, 16'h0200, 18'd256);
    beat(16'h0400, 16'h0200, 18'd256);
    beat(16'h0800, 16'hFC00, 18'h3FF00);
    beat(16'h0800, 16'hFC00, 18'h3FF00);
    beat(16'h0800, 16'hFC00, 18'h3FF00);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_pulse_after", out_valid, 0);
    chk("b2b_results_seen", checks - ov_a, 3);
    chk("b2b_spacing", pop_last - pop_prev, 4);

    drain();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Serial multiply-accumulate neuron core: consumes one signed (input, weight) pair per cycle over a valid/ready stream, adds a bias, and produces the pre-activation sum. Sits directly upstream of the sigmoid activation stage. `acc_out` is sized and formatted to drive the sigmoid input without conversion: `QM+QN+G` bits, QN fractional bits. One vector of `N_INPUTS` pairs yields one result.

## Interface
- `N_INPUTS`, 3: pairs per vector, ≥1.
- `G`, 2: accumulator guard bits, matching the sigmoid's `N`.
- `QM`, 6: integer bits of operands, including sign.
- `QN`, 10: fractional bits of operands and result.
- Local `W = QM+QN+G`: accumulator and result width.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: `x`/`w`/`bias` are valid.
- `in_ready`, out, 1: block accepts a beat.
- `x`, in, QM+QN: signed input sample, Q(QM.QN).
- `w`, in, QM+QN: signed weight, Q(QM.QN).
- `bias`, in, W: signed bias, QN fractional bits. Sampled only on the first beat of a vector.
- `out_valid`, out, 1: `acc_out` holds a completed sum.
- `out_ready`, in, 1: downstream consumes the result.
- `acc_out`, out, W: signed pre-activation sum, QN fractional bits.

## Operation
- **Beat acceptance:** a beat is accepted on a rising edge with `in_valid && in_ready`.
- **FSM states:** IDLE, ACC, HOLD.
- **IDLE, beat accepted:**
  - `acc <= bias + p`.
  - `cnt <= 1`.
  - Next state: ACC, or HOLD if `N_INPUTS==1`.
- **ACC, beat accepted:**
  - `acc <= acc + p`.
  - `cnt <= cnt+1`.
  - Next state: HOLD when the `N_INPUTS`-th beat is accepted.
- **HOLD:** `out_valid=1`. When `out_ready` is high, go to IDLE on that edge.
- **`in_ready`:** `in_ready = (state != HOLD)`. It is purely a function of state and does not depend on `out_ready`.
- **Gaps:** idle cycles (`in_valid=0`) inside a vector are allowed. State and count are held.
- **Product path:**
  - `p_full = x*w`: signed, 2(QM+QN) bits, 2QN fractional bits.
  - `p = p_full >>> QN`: arithmetic shift, i.e. floor (round toward −∞).
  - `p` is then saturated to W-bit signed range `[-2^(W-1), 2^(W-1)-1]`.
- **Sum:** computed at W+1 bits, then reduced to W bits per Configuration.
- **`acc_out`:** driven directly from the `acc` register. It is stable for the whole of HOLD.
- **Reset:**
  - Outputs: `out_valid=0`, `acc_out=0`, `in_ready=1` from the first cycle after reset.
  - Internal: state IDLE, `cnt=0`.
  - Reset mid-vector or during HOLD discards the partial or pending result.
  - Beats presented while `rst` is high are not accepted.

## Timing
- **Latency:** `out_valid` rises on the clock edge that accepts the last beat, so it is visible the cycle after acceptance.
- **Throughput:** at most one vector per `N_INPUTS+1` cycles. HOLD lasts at least one cycle and accepts no beats.
- **Back-to-back vectors:** the first beat of the next vector can be accepted in the cycle after the HOLD→IDLE transition.
- **Backpressure:** with `out_ready` low, HOLD persists indefinitely and `acc_out` is unchanged.
- **Combinational paths:** the only input→output paths are multiply and add, which end at registers. No input drives an output in the same cycle.

## Configuration
- **`NEURON_MAC_ACC_SAT_EN` defined:** each W+1-bit sum is clamped to `[-2^(W-1), 2^(W-1)-1]` before writing `acc`.
- **Not defined:**
  - The sum wraps modulo 2^W (low W bits kept).
  - Overflow-free operation is guaranteed only when the integrator ensures `N_INPUTS+1 ≤ 2^G` and operands are in range.
- Product saturation is always present.

## Test plan
- **Basic sum:**
  - Stimulus: defaults, `bias=256` (0.25), 3 beats `x=0x0400` (1.0), `w=0x0200` (0.5), `out_ready=1`.
  - Response: `out_valid` high the cycle after the 3rd beat, `acc_out=1792` (1.75). Returns to IDLE next cycle, `in_ready=1`.
- **Floor rounding:**
  - Stimulus: `bias=0`, beats `(x=-1, w=0x0200)`, `(0,0)`, `(0,0)`.
  - Response: `acc_out=-1` (0x3FFFF).
- **Saturation:**
  - Stimulus: `bias=0`, 3 beats `x=w=0x7FFF`.
  - Response with `NEURON_MAC_ACC_SAT_EN`: `acc_out=131071`.
  - Response without: `acc_out=131069` (wrapped).
- **Backpressure and gaps:**
  - Stimulus: `in_valid` low for 2 cycles between beats 1 and 2; `out_ready` low for 5 cycles in HOLD.
  - Response: `acc_out` identical to the basic-sum result, stable throughout HOLD. `in_ready=0` throughout HOLD. Beats offered during HOLD are not consumed.
- **Reset mid-vector:**
  - Stimulus: accept 2 beats, assert `rst` for 1 cycle, then send a full basic-sum vector.
  - Response: `out_valid=0` and `acc_out=0` after reset. Next result is 1792, with no contribution from the discarded beats.
- **Back-to-back vectors:**
  - Stimulus: two vectors with `in_valid` and `out_ready` held high.
  - Response: `out_valid` pulses for exactly 1 cycle per vector, 4 cycles apart. Both results are correct.
